sh4a_alu_issue: RTL and testbench
=================================

Name: sh4a_alu_issue

Overview:
- Issue/writeback front end for sh4a_alu. Holds the SH-4 general register file: R0–R7 in two banks plus R8–R15.
- Accepts one two-register ALU instruction at a time (ADD Rm,Rn / SUB Rm,Rn) and reads Rn/Rm.
- Drives the ALU src1/src2/op inputs, waits for the registered ALU result, then writes it back to Rn.
- Bank select comes from the ALU status output, bit 29 (RB).

Parameters:
- ALU_LATENCY, 1, number of cycles the FSM spends in EXEC waiting for the registered ALU dest (≥1).
- RB_BIT, 29, bit of alu_status used as register-bank select.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction present
- issue_ready  out  1  block can accept instruction
- issue_op  in  6  opcode (sh4a_op.vh encoding)
- issue_rn  in  4  destination/first source register
- issue_rm  in  4  second source register
- alu_src1  out  32  to ALU src1 (value of Rn)
- alu_src2  out  32  to ALU src2 (value of Rm)
- alu_op  out  6  to ALU op
- alu_dest  in  32  ALU result (registered in ALU)
- alu_status  in  32  ALU status output
- wb_valid  out  1  one-cycle writeback strobe
- wb_reg  out  4  register written
- wb_data  out  32  value written
- dbg_addr  in  5  debug read index
- dbg_data  out  32  debug read data (combinational)

Behaviour:
- Reset is synchronous, active-high, all state:
  - FSM → IDLE; all 24 registers → 0.
  - alu_src1/alu_src2 → 0; alu_op → 0 (ADD code is not required; any value).
  - wb_valid → 0, wb_reg → 0, wb_data → 0.
  - issue_ready → 0 during reset, 1 the cycle after reset deasserts.
- Reset mid-operation abandons the instruction; no writeback occurs.
- FSM states are IDLE → EXEC → WB → IDLE.
- IDLE:
  - issue_ready = 1.
  - Accept on issue_valid & issue_ready at a clock edge.
  - On accept: latch rn, op and rb = alu_status[RB_BIT]; load alu_src1 = R[rn]; load alu_src2 = R[rm]; load alu_op = op.
  - Register reads use the banked view: index 0–7 → bank rb, index 8–15 → shared.
  - Go to EXEC and load the latency counter with ALU_LATENCY.
- EXEC:
  - issue_ready = 0; ALU inputs held stable.
  - Counter decrements each cycle; at 1, go to WB.
- WB (one cycle):
  - issue_ready = 0.
  - If the latched op is ADD or SUBTRACT:
    - wb_valid = 1, wb_reg = rn, wb_data = alu_dest.
    - R[rn] in the bank latched at issue ← alu_dest at the end of the cycle.
  - Any other op: wb_valid = 0, no register change (NOP).
  - Return to IDLE.
- Timing with ALU_LATENCY = 1:
  - Accept at edge 0; ALU registers dest at edge 1; wb_valid high between edges 1 and 2.
  - The write commits at edge 2; the next accept is possible at edge 3.
  - Throughput is one instruction per (ALU_LATENCY + 2) cycles.
- issue_valid outside IDLE is ignored. Source must hold the instruction until ready.
- wb_valid, wb_reg and wb_data are registered. wb_reg/wb_data hold their last values when wb_valid = 0.
- A bank change on alu_status between issue and WB does not redirect the write: the bank latched at issue is used.
- Arithmetic wraps modulo 2^32; the ALU produces it and this block just forwards the 32 bits.
- Rn == Rm is legal: both source ports read the same pre-write value.
- Debug port dbg_addr mapping:
  - 0–7 → bank0 R0–R7
  - 8–15 → bank1 R0–R7
  - 16–23 → R8–R15
  - 24–31 → 0
- A debug read of a register being written in WB returns the old value until the commit edge.

Test Plan:
- Reset, then check outputs: dbg_data = 0 for all 32 indices, issue_ready = 1 the cycle after release, wb_valid = 0.
- Seed registers through a sequence of ADDs, bank 1 (RB = 1 after ALU reset):
  - ADD R1,R1 with R1 = 0 → wb_data 0.
  - Preload by test hook or chain: issue ADD rn = 8, rm = 9 with R8 = 5, R9 = 7.
  - Expect wb_valid in WB cycle, wb_reg = 8, wb_data = 12, dbg[16] = 12.
- SUB wrap: R10 = 0, R11 = 1, SUB rn = 10, rm = 11 → wb_data = 32'hFFFF_FFFF, dbg[18] = FFFF_FFFF.
- Banking:
  - With alu_status[29] = 1, ADD into R2 = 3 → dbg[10] = 3, dbg[2] unchanged.
  - Force alu_status[29] = 0 and repeat → dbg[2] updates.
  - Flip status during EXEC → write still goes to the issue-time bank.
- Handshake:
  - Hold issue_valid high continuously → accepts exactly every 3 cycles (ALU_LATENCY = 1).
  - issue_ready low in EXEC/WB.
  - Unknown op → no wb_valid, registers unchanged.
- Reset asserted during EXEC → no wb_valid, dbg all 0, IDLE with issue_ready = 1 after release.

Source files
------------

// File: rtl/sh4a_alu_issue.sv
// Issue/writeback front end for the sh4a ALU: banked SH-4 register file, operand fetch,
// latency wait for the registered ALU result and a one-cycle writeback to Rn.
//
// state | meaning
// IDLE  | ready for an instruction; accept latches rn, op, bank and loads ALU operands
// EXEC  | ALU operands held; latency counter runs down to 1
// WB    | ALU result valid; ADD/SUB commit to Rn in the issue-time bank
module sh4a_alu_issue #(
   parameter int         ALU_LATENCY = 1,
   parameter int         RB_BIT      = 29,
   parameter logic [5:0] OP_ADD      = 6'h01,
   parameter logic [5:0] OP_SUB      = 6'h02
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [5:0]  issue_op,
   input  logic [3:0]  issue_rn,
   input  logic [3:0]  issue_rm,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic [5:0]  alu_op,
   input  logic [31:0] alu_dest,
   input  logic [31:0] alu_status,
   output logic        wb_valid,
   output logic [3:0]  wb_reg,
   output logic [31:0] wb_data,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rb_q;
   logic [3:0]      rn_q;
   logic [31:0]     wb_data_q;
   logic [31:0]     bank0 [8];
   logic [31:0]     bank1 [8];
   logic [31:0]     bank_hi [8];
   logic [31:0]     rd1, rd2;
   logic            cur_rb, accept, enter_wb, op_arith;

   assign cur_rb   = alu_status[RB_BIT];
   assign accept   = (state_q == IDLE) && issue_valid && issue_ready;
   assign enter_wb = (state_q == EXEC) && (cnt_q == CW'(1));
   assign op_arith = (alu_op == OP_ADD) || (alu_op == OP_SUB);

   // Indices 0-7 follow the current bank, 8-15 are shared.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (issue_rn[3])  rd1 = bank_hi[issue_rn[2:0]];
      else if (cur_rb)  rd1 = bank1[issue_rn[2:0]];
      else              rd1 = bank0[issue_rn[2:0]];
      if (issue_rm[3])  rd2 = bank_hi[issue_rm[2:0]];
      else if (cur_rb)  rd2 = bank1[issue_rm[2:0]];
      else              rd2 = bank0[issue_rm[2:0]];
   end

   always_comb begin
      dbg_data = '0;
      case (dbg_addr[4:3])
         2'd0:    dbg_data = bank0[dbg_addr[2:0]];
         2'd1:    dbg_data = bank1[dbg_addr[2:0]];
         2'd2:    dbg_data = bank_hi[dbg_addr[2:0]];
         default: dbg_data = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
               cnt_d   = CW'(ALU_LATENCY);
            end
         end
         EXEC: begin
            if (cnt_q == CW'(1)) state_d = WB;
            else                 cnt_d   = cnt_q - CW'(1);
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         issue_ready <= 1'b0;
         rb_q        <= 1'b0;
         rn_q        <= '0;
         alu_src1    <= '0;
         alu_src2    <= '0;
         alu_op      <= '0;
         wb_valid    <= 1'b0;
         wb_reg      <= '0;
         wb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         issue_ready <= (state_d == IDLE);
         if (accept) begin
            rb_q     <= cur_rb;
            rn_q     <= issue_rn;
            alu_src1 <= rd1;
            alu_src2 <= rd2;
            alu_op   <= issue_op;
         end
         wb_valid <= enter_wb && op_arith;
         if (enter_wb && op_arith) wb_reg <= rn_q;
         if (wb_valid) wb_data_q <= alu_dest;
      end
   end

   // The ALU result is only valid during WB, so the strobe cycle forwards it directly.
   assign wb_data = wb_valid ? alu_dest : wb_data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            bank0[i]   <= '0;
            bank1[i]   <= '0;
            bank_hi[i] <= '0;
         end
      end else if (wb_valid) begin
         if (rn_q[3])   bank_hi[rn_q[2:0]] <= alu_dest;
         else if (rb_q) bank1[rn_q[2:0]]   <= alu_dest;
         else           bank0[rn_q[2:0]]   <= alu_dest;
      end
   end

endmodule

// File: tb/tb_sh4a_alu_issue.sv
// Bench for sh4a_alu_issue: a registered ALU stand-in, a transaction-level register-file
// model checked every cycle, and directed cases with hand-computed results.
module tb_sh4a_alu_issue;
   localparam int         LAT    = 1;
   localparam logic [5:0] OP_ADD = 6'h01;
   localparam logic [5:0] OP_SUB = 6'h02;

   logic        clk = 1'b0;
   logic        reset, issue_valid, issue_ready;
   logic [5:0]  issue_op, alu_op;
   logic [3:0]  issue_rn, issue_rm, wb_reg;
   logic [31:0] alu_src1, alu_src2, alu_dest, alu_status, wb_data, dbg_data;
   logic        wb_valid;
   logic [4:0]  dbg_addr;

   logic        force_en;
   logic [31:0] force_val;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sh4a_alu_issue #(.ALU_LATENCY(LAT), .RB_BIT(29), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_rn(issue_rn), .issue_rm(issue_rm),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
      .alu_dest(alu_dest), .alu_status(alu_status),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // ALU stand-in: result registered every cycle; force injects preload values.
   initial alu_dest = '0;
   always @(posedge clk) begin
      if (force_en)              alu_dest <= force_val;
      else if (alu_op == OP_SUB) alu_dest <= alu_src1 - alu_src2;
      else if (alu_op == OP_ADD) alu_dest <= alu_src1 + alu_src2;
      else                       alu_dest <= alu_src1 ^ alu_src2;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference model: m_reg[0]/m_reg[1] are the R0-R7 banks, m_reg[2] holds R8-R15.
   logic [31:0] m_reg [3][8];
   logic        exp_ready, exp_wb_valid;
   logic [3:0]  exp_wb_reg;
   logic [31:0] exp_wb_data;
   bit          chk_en = 0, t_pend = 0, t_wb = 0, t_arith = 0, t_rb = 0;
   int          t_left = 0, cyc = 0;
   logic [3:0]  t_rn;
   logic [5:0]  t_op;
   logic [31:0] t_s1, t_s2, t_res;
   int          acc_q[$];

   function automatic logic [31:0] m_read(input logic [3:0] r, input logic rb);
      int bank;
      bank = r[3] ? 2 : (rb ? 1 : 0);
      return m_reg[bank][r % 8];
   endfunction

   function automatic logic [31:0] m_dbg(input logic [4:0] a);
      if (a >= 24) return 32'h0;
      return m_reg[a / 8][a % 8];
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_ready});
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, exp_wb_valid});
            chk("wb_reg", {28'b0, wb_reg}, {28'b0, exp_wb_reg});
            chk("wb_data", wb_data, exp_wb_data);
            chk("dbg_data", dbg_data, m_dbg(dbg_addr));
            if (t_pend || t_wb) begin
               chk("alu_src1", alu_src1, t_s1);
               chk("alu_src2", alu_src2, t_s2);
               chk("alu_op", {26'b0, alu_op}, {26'b0, t_op});
            end
         end
         // Predict what the coming clock edge does.
         cyc++;
         if (reset) begin
            for (int b = 0; b < 3; b++)
               for (int i = 0; i < 8; i++) m_reg[b][i] = '0;
            exp_ready = 0; exp_wb_valid = 0; exp_wb_reg = '0; exp_wb_data = '0;
            t_pend = 0; t_wb = 0; chk_en = 1;
         end else if (t_wb) begin
            if (t_arith) m_reg[t_rn[3] ? 2 : int'(t_rb)][t_rn % 8] = t_res;
            t_wb = 0; exp_wb_valid = 0; exp_ready = 1;
         end else if (t_pend) begin
            t_left--;
            if (t_left == 0) begin
               t_pend = 0; t_wb = 1;
               exp_wb_valid = t_arith;
               if (t_arith) begin
                  exp_wb_reg  = t_rn;
                  exp_wb_data = t_res;
               end
            end
         end else if (exp_ready && issue_valid) begin
            t_rn = issue_rn; t_op = issue_op; t_rb = alu_status[29];
            t_s1 = m_read(issue_rn, t_rb);
            t_s2 = m_read(issue_rm, t_rb);
            t_arith = (issue_op == OP_ADD) || (issue_op == OP_SUB);
            t_res = force_en ? force_val : ((issue_op == OP_SUB) ? t_s1 - t_s2 : t_s1 + t_s2);
            t_pend = 1; t_left = LAT; exp_ready = 0;
            acc_q.push_back(cyc);
         end else begin
            exp_ready = 1;
         end
      end
   end

   task automatic issue(input logic [5:0] op, input logic [3:0] rn, input logic [3:0] rm);
      bit ok;
      @(posedge clk); #1;
      issue_valid = 1; issue_op = op; issue_rn = rn; issue_rm = rm;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (issue_ready === 1'b1) ok = 1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL issue_timeout: issue_ready never high, got %b expected 1", issue_ready);
         issue_valid = 0;
      end else begin
         @(posedge clk); #1;
         issue_valid = 0;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); #1;
         if (issue_ready === 1'b1) ok = 1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: issue_ready got %b expected 1", issue_ready);
      end
   endtask

   task automatic wait_wb(output logic v, output logic [3:0] r, output logic [31:0] d);
      bit done;
      v = 0; r = '0; d = '0; done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge clk); #1;
         if (wb_valid === 1'b1) begin
            v = 1; r = wb_reg; d = wb_data; done = 1;
         end else if (issue_ready === 1'b1) begin
            done = 1;
         end
      end
   endtask

   task automatic dbg_chk(input logic [4:0] a, input logic [31:0] exp, input string nm);
      @(posedge clk); #1;
      dbg_addr = a;
      @(negedge clk); #1;
      chk(nm, dbg_data, exp);
   endtask

   task automatic preload(input logic [3:0] r, input logic [31:0] val, input logic rb);
      force_en = 1; force_val = val; alu_status[29] = rb;
      issue(OP_ADD, r, r);
      wait_idle();
      force_en = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        v;
      logic [3:0]  r;
      logic [31:0] d;
      reset = 1; issue_valid = 0; issue_op = '0; issue_rn = '0; issue_rm = '0;
      dbg_addr = '0; alu_status = 32'h2000_0000; force_en = 0; force_val = '0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", {31'b0, issue_ready}, 32'd1);
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      for (int a = 0; a < 32; a++) dbg_chk(5'(a), 32'h0, "rst_dbg");

      // ADD R1,R1 on zeros, bank 1
      issue(OP_ADD, 4'd1, 4'd1);
      wait_wb(v, r, d);
      chk("add0_valid", {31'b0, v}, 32'd1);
      chk("add0_reg", {28'b0, r}, 32'd1);
      chk("add0_data", d, 32'd0);
      wait_idle();

      preload(4'd8, 32'd5, 1'b1);
      preload(4'd9, 32'd7, 1'b1);
      issue(OP_ADD, 4'd8, 4'd9);
      wait_wb(v, r, d);
      chk("add_valid", {31'b0, v}, 32'd1);
      chk("add_reg", {28'b0, r}, 32'd8);
      chk("add_data", d, 32'd12);
      wait_idle();
      dbg_chk(5'd16, 32'd12, "add_dbg16");

      preload(4'd10, 32'd0, 1'b1);
      preload(4'd11, 32'd1, 1'b1);
      issue(OP_SUB, 4'd10, 4'd11);
      wait_wb(v, r, d);
      chk("sub_wrap_data", d, 32'hFFFF_FFFF);
      chk("sub_wrap_reg", {28'b0, r}, 32'd10);
      wait_idle();
      dbg_chk(5'd18, 32'hFFFF_FFFF, "sub_dbg18");

      // Banking
      preload(4'd2, 32'd3, 1'b1);
      dbg_chk(5'd10, 32'd3, "bank1_r2");
      dbg_chk(5'd2, 32'd0, "bank0_r2_untouched");
      preload(4'd2, 32'd3, 1'b0);
      dbg_chk(5'd2, 32'd3, "bank0_r2");
      force_en = 1; force_val = 32'd9; alu_status[29] = 0;
      issue(OP_ADD, 4'd2, 4'd2);
      alu_status[29] = 1;
      wait_idle();
      force_en = 0;
      dbg_chk(5'd2, 32'd9, "flip_bank0_r2");
      dbg_chk(5'd10, 32'd3, "flip_bank1_r2");

      // bank0 R2 (9) + R10 (FFFF_FFFF) wraps to 8
      alu_status[29] = 0;
      issue(OP_ADD, 4'd2, 4'd10);
      wait_wb(v, r, d);
      chk("add_wrap_data", d, 32'd8);
      wait_idle();
      dbg_chk(5'd2, 32'd8, "add_wrap_dbg2");

      // Unknown op: no writeback, nothing changes
      issue(6'h3F, 4'd8, 4'd9);
      wait_wb(v, r, d);
      chk("nop_valid", {31'b0, v}, 32'd0);
      wait_idle();
      dbg_chk(5'd16, 32'd12, "nop_dbg16");

      // Back-to-back: issue_valid held high
      acc_q.delete();
      alu_status[29] = 1;
      @(posedge clk); #1;
      issue_valid = 1; issue_op = OP_ADD; issue_rn = 4'd12; issue_rm = 4'd13;
      repeat (16) @(posedge clk);
      #1 issue_valid = 0;
      wait_idle();
      chk("b2b_accepts_ge5", {31'b0, acc_q.size() >= 5}, 32'd1);
      for (int i = 1; i < acc_q.size(); i++)
         chk("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'(LAT + 2));

      // Reset during EXEC
      force_en = 1; force_val = 32'd77; alu_status[29] = 1;
      issue(OP_ADD, 4'd3, 4'd3);
      reset = 1;
      @(posedge clk); #1;
      reset = 0; force_en = 0;
      @(negedge clk); #1;
      chk("rst_exec_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_exec_ready_low", {31'b0, issue_ready}, 32'd0);
      @(negedge clk); #1;
      chk("rst_exec_ready", {31'b0, issue_ready}, 32'd1);
      for (int a = 0; a < 32; a++) dbg_chk(5'(a), 32'h0, "rst_exec_dbg");

      // Randomized traffic against the model
      for (int k = 0; k < 150; k++) begin
         int sel;
         int gap;
         logic [5:0] op;
         sel = $urandom_range(0, 9);
         if (sel < 5)      op = OP_ADD;
         else if (sel < 9) op = OP_SUB;
         else              op = 6'($urandom_range(3, 63));
         force_en   = ($urandom_range(0, 3) == 0);
         force_val  = $urandom;
         alu_status = $urandom;
         dbg_addr   = 5'($urandom);
         gap = $urandom_range(0, 2);
         repeat (gap) @(posedge clk);
         issue(op, 4'($urandom), 4'($urandom));
         if ($urandom_range(0, 2) == 0) alu_status[29] = ~alu_status[29];
         wait_idle();
         force_en = 0;
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
